// File: rtl/defines.sv
// Shared core definitions: lane count, scalar/mask/thread types and the decoded instruction.
package defines;

    localparam int NUM_VECTOR_LANES = 16;
    localparam int THREADS_PER_CORE = 4;
    localparam int FLOAT32_EXP_WIDTH = 8;

    typedef logic [31:0] scalar_t;
    typedef logic [NUM_VECTOR_LANES-1:0] vector_lane_mask_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
    typedef logic [$clog2(NUM_VECTOR_LANES)-1:0] subcycle_t;

    typedef enum logic [5:0] {
        OP_ADD_F   = 6'h20,
        OP_SUB_F   = 6'h21,
        OP_MUL_F   = 6'h22,
        OP_IMUL    = 6'h07,
        OP_CMPGT_F = 6'h2c,
        OP_FTOI    = 6'h1b,
        OP_ITOF    = 6'h2a
    } alu_op_t;

    typedef struct packed {
        logic    has_dest;
        logic    dest_is_vector;
        logic [4:0] dest_reg;
        alu_op_t alu_op;
    } decoded_instruction_t;

endpackage

// File: rtl/fp_lzc32.sv
// Combinational 32-bit leading-zero counter; all-zero input yields 32.
module fp_lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  lzc
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        lzc = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i])
                lzc = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fp_execute_stage4.sv
// FP pipeline stage 4: per-lane normalization shift plus one register stage for all fields.
// Optional subnormal flush-to-zero when FP_FLUSH_SUBNORMAL_EN is defined.
module fp_execute_stage4
    import defines::*;
(
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        fx3_instruction_valid,
    input  decoded_instruction_t        fx3_instruction,
    input  vector_lane_mask_t           fx3_mask_value,
    input  local_thread_idx_t           fx3_thread_idx,
    input  subcycle_t                   fx3_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0] fx3_result_is_inf,
    input  logic [NUM_VECTOR_LANES-1:0] fx3_result_is_nan,
    input  logic [NUM_VECTOR_LANES-1:0] fx3_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0] fx3_logical_subtract,
    input  logic [NUM_VECTOR_LANES-1:0] fx3_mul_sign,
    input  logic [FLOAT32_EXP_WIDTH-1:0] fx3_add_exponent [NUM_VECTOR_LANES],
    input  logic [FLOAT32_EXP_WIDTH-1:0] fx3_mul_exponent [NUM_VECTOR_LANES],
    input  scalar_t                     fx3_add_significand [NUM_VECTOR_LANES],
    input  logic [63:0]                 fx3_significand_product [NUM_VECTOR_LANES],

    output logic                        fx4_instruction_valid,
    output decoded_instruction_t        fx4_instruction,
    output vector_lane_mask_t           fx4_mask_value,
    output local_thread_idx_t           fx4_thread_idx,
    output subcycle_t                   fx4_subcycle,
    output logic [NUM_VECTOR_LANES-1:0] fx4_result_is_inf,
    output logic [NUM_VECTOR_LANES-1:0] fx4_result_is_nan,
    output logic [NUM_VECTOR_LANES-1:0] fx4_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0] fx4_logical_subtract,
    output logic [NUM_VECTOR_LANES-1:0] fx4_mul_sign,
    output logic [FLOAT32_EXP_WIDTH-1:0] fx4_add_exponent [NUM_VECTOR_LANES],
    output logic [FLOAT32_EXP_WIDTH-1:0] fx4_mul_exponent [NUM_VECTOR_LANES],
    output scalar_t                     fx4_add_significand [NUM_VECTOR_LANES],
    output logic [63:0]                 fx4_significand_product [NUM_VECTOR_LANES],
    output logic [5:0]                  fx4_norm_shift [NUM_VECTOR_LANES]
);

    logic                         is_ftoi;
    logic [5:0]                   lzc [NUM_VECTOR_LANES];
    logic [5:0]                   norm_shift_d [NUM_VECTOR_LANES];
    scalar_t                      add_significand_d [NUM_VECTOR_LANES];
    logic [FLOAT32_EXP_WIDTH-1:0] add_exponent_d [NUM_VECTOR_LANES];

    assign is_ftoi = fx3_instruction.alu_op == OP_FTOI;

    for (genvar lane = 0; lane < NUM_VECTOR_LANES; lane++) begin : gen_lane
        fp_lzc32 u_lzc (
            .value(fx3_add_significand[lane]),
            .lzc  (lzc[lane])
        );
    end

    always_comb begin
        for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
            // FTOI results were already aligned upstream.
            norm_shift_d[lane] = is_ftoi ? 6'd0 : lzc[lane];
            add_significand_d[lane] = fx3_add_significand[lane];
            add_exponent_d[lane] = fx3_add_exponent[lane];
`ifdef FP_FLUSH_SUBNORMAL_EN
            // Normalized exponent (exp - lzc + 8) would be <= 0, or the value is zero/denormal.
            if (!is_ftoi && (({1'b0, fx3_add_exponent[lane]} + 9'd8 <= {3'b000, lzc[lane]})
                    || fx3_add_exponent[lane] == '0 || fx3_add_significand[lane] == '0)) begin
                add_significand_d[lane] = '0;
                add_exponent_d[lane] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk, posedge reset) begin
        if (reset)
            fx4_instruction_valid <= 1'b0;
        else
            fx4_instruction_valid <= fx3_instruction_valid;
    end

    // Datapath loads every cycle; stage 5 qualifies by valid.
    always_ff @(posedge clk) begin
        fx4_instruction <= fx3_instruction;
        fx4_mask_value <= fx3_mask_value;
        fx4_thread_idx <= fx3_thread_idx;
        fx4_subcycle <= fx3_subcycle;
        fx4_result_is_inf <= fx3_result_is_inf;
        fx4_result_is_nan <= fx3_result_is_nan;
        fx4_add_result_sign <= fx3_add_result_sign;
        fx4_logical_subtract <= fx3_logical_subtract;
        fx4_mul_sign <= fx3_mul_sign;
        fx4_add_exponent <= add_exponent_d;
        fx4_mul_exponent <= fx3_mul_exponent;
        fx4_add_significand <= add_significand_d;
        fx4_significand_product <= fx3_significand_product;
        fx4_norm_shift <= norm_shift_d;
    end

endmodule

// File: tb/tb_fp_execute_stage4.sv
// Self-checking bench for fp_execute_stage4: directed cases plus randomized traffic vs a reference model.
module tb_fp_execute_stage4;
    import defines::*;

    localparam int L = NUM_VECTOR_LANES;
`ifdef FP_FLUSH_SUBNORMAL_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic                 fx3_instruction_valid;
    decoded_instruction_t fx3_instruction;
    vector_lane_mask_t    fx3_mask_value;
    local_thread_idx_t    fx3_thread_idx;
    subcycle_t            fx3_subcycle;
    logic [L-1:0]         fx3_result_is_inf, fx3_result_is_nan, fx3_add_result_sign;
    logic [L-1:0]         fx3_logical_subtract, fx3_mul_sign;
    logic [7:0]           fx3_add_exponent [L];
    logic [7:0]           fx3_mul_exponent [L];
    scalar_t              fx3_add_significand [L];
    logic [63:0]          fx3_significand_product [L];

    logic                 fx4_instruction_valid;
    decoded_instruction_t fx4_instruction;
    vector_lane_mask_t    fx4_mask_value;
    local_thread_idx_t    fx4_thread_idx;
    subcycle_t            fx4_subcycle;
    logic [L-1:0]         fx4_result_is_inf, fx4_result_is_nan, fx4_add_result_sign;
    logic [L-1:0]         fx4_logical_subtract, fx4_mul_sign;
    logic [7:0]           fx4_add_exponent [L];
    logic [7:0]           fx4_mul_exponent [L];
    scalar_t              fx4_add_significand [L];
    logic [63:0]          fx4_significand_product [L];
    logic [5:0]           fx4_norm_shift [L];

    int checks = 0;
    int errors = 0;

    fp_execute_stage4 dut (
        .clk                    (clk),
        .reset                  (reset),
        .fx3_instruction_valid  (fx3_instruction_valid),
        .fx3_instruction        (fx3_instruction),
        .fx3_mask_value         (fx3_mask_value),
        .fx3_thread_idx         (fx3_thread_idx),
        .fx3_subcycle           (fx3_subcycle),
        .fx3_result_is_inf      (fx3_result_is_inf),
        .fx3_result_is_nan      (fx3_result_is_nan),
        .fx3_add_result_sign    (fx3_add_result_sign),
        .fx3_logical_subtract   (fx3_logical_subtract),
        .fx3_mul_sign           (fx3_mul_sign),
        .fx3_add_exponent       (fx3_add_exponent),
        .fx3_mul_exponent       (fx3_mul_exponent),
        .fx3_add_significand    (fx3_add_significand),
        .fx3_significand_product(fx3_significand_product),
        .fx4_instruction_valid  (fx4_instruction_valid),
        .fx4_instruction        (fx4_instruction),
        .fx4_mask_value         (fx4_mask_value),
        .fx4_thread_idx         (fx4_thread_idx),
        .fx4_subcycle           (fx4_subcycle),
        .fx4_result_is_inf      (fx4_result_is_inf),
        .fx4_result_is_nan      (fx4_result_is_nan),
        .fx4_add_result_sign    (fx4_add_result_sign),
        .fx4_logical_subtract   (fx4_logical_subtract),
        .fx4_mul_sign           (fx4_mul_sign),
        .fx4_add_exponent       (fx4_add_exponent),
        .fx4_mul_exponent       (fx4_mul_exponent),
        .fx4_add_significand    (fx4_add_significand),
        .fx4_significand_product(fx4_significand_product),
        .fx4_norm_shift         (fx4_norm_shift)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count zeros from the MSB down until the first one.
    function automatic int ref_lzc(logic [31:0] v);
        int n = 0;
        while (n < 32 && v[31 - n] == 1'b0)
            n++;
        return n;
    endfunction

    function automatic int ref_shift(alu_op_t op, logic [31:0] sig);
        return (op == OP_FTOI) ? 0 : ref_lzc(sig);
    endfunction

    function automatic bit ref_flush(alu_op_t op, logic [7:0] e, logic [31:0] sig);
        int normalized = int'(e) - ref_lzc(sig) + 8;
        return FLUSH && op != OP_FTOI && (normalized <= 0 || e == 0 || sig == 0);
    endfunction

    function automatic alu_op_t pick_op(int unsigned r);
        case (r % 7)
            0: return OP_ADD_F;
            1: return OP_SUB_F;
            2: return OP_MUL_F;
            3: return OP_IMUL;
            4: return OP_CMPGT_F;
            5: return OP_FTOI;
            default: return OP_ITOF;
        endcase
    endfunction

    task automatic randomize_inputs();
        fx3_instruction_valid = 1'($urandom);
        fx3_instruction.has_dest = 1'($urandom);
        fx3_instruction.dest_is_vector = 1'($urandom);
        fx3_instruction.dest_reg = 5'($urandom);
        fx3_instruction.alu_op = pick_op($urandom);
        fx3_mask_value = L'($urandom);
        fx3_thread_idx = local_thread_idx_t'($urandom);
        fx3_subcycle = subcycle_t'($urandom);
        fx3_result_is_inf = L'($urandom);
        fx3_result_is_nan = L'($urandom);
        fx3_add_result_sign = L'($urandom);
        fx3_logical_subtract = L'($urandom);
        fx3_mul_sign = L'($urandom);
        for (int i = 0; i < L; i++) begin
            fx3_add_exponent[i] = 8'($urandom);
            fx3_mul_exponent[i] = 8'($urandom);
            fx3_add_significand[i] = $urandom >> $urandom_range(0, 32);
            fx3_significand_product[i] = {$urandom, $urandom};
        end
    endtask

    task automatic test_reset();
        randomize_inputs();
        fx3_instruction_valid = 1'b1;
        #1;
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", fx4_instruction_valid);
        end
        tick();
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got %b want 0", fx4_instruction_valid);
        end
        fx3_instruction_valid = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_bubble: got %b want 0", fx4_instruction_valid);
        end
    endtask

    task automatic test_norm_shift();
        logic [31:0] sigs [4] = '{32'h0080_0000, 32'h0100_0000, 32'h0000_0100, 32'h0};
        logic [7:0]  exps [4] = '{8'h7f, 8'h80, 8'h02, 8'h10};
        int          want [4] = '{8, 7, 23, 32};
        randomize_inputs();
        fx3_instruction_valid = 1'b1;
        fx3_instruction.alu_op = OP_ADD_F;
        for (int i = 0; i < 4; i++) begin
            fx3_add_significand[i] = sigs[i];
            fx3_add_exponent[i] = exps[i];
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(fx4_norm_shift[i]) != want[i]) begin
                errors++;
                $display("FAIL norm_shift lane%0d: got %0d want %0d", i, fx4_norm_shift[i],
                         want[i]);
            end
        end
        checks++;
        if (fx4_add_exponent[0] !== 8'h7f || fx4_add_significand[0] !== 32'h0080_0000) begin
            errors++;
            $display("FAIL echo lane0: got exp %h sig %h want 7f 00800000", fx4_add_exponent[0],
                     fx4_add_significand[0]);
        end
        // Exponent 2 with 23 leading zeros: flushed only when the option is built in.
        checks++;
        if (fx4_add_significand[2] !== (FLUSH ? 32'h0 : 32'h100)
                || fx4_add_exponent[2] !== (FLUSH ? 8'h0 : 8'h02)) begin
            errors++;
            $display("FAIL flush lane2: got exp %h sig %h flush=%0d", fx4_add_exponent[2],
                     fx4_add_significand[2], FLUSH);
        end
        checks++;
        if (fx4_add_exponent[3] !== (FLUSH ? 8'h0 : 8'h10)) begin
            errors++;
            $display("FAIL zero_sig lane3: got exp %h flush=%0d", fx4_add_exponent[3], FLUSH);
        end
    endtask

    task automatic test_ftoi();
        randomize_inputs();
        fx3_instruction_valid = 1'b1;
        fx3_instruction.alu_op = OP_FTOI;
        fx3_add_significand[0] = 32'h5;
        fx3_add_exponent[0] = 8'h01;
        fx3_significand_product[0] = 64'h0000_4000_0000_0000;
        tick();
        checks++;
        if (fx4_norm_shift[0] !== 6'd0) begin
            errors++;
            $display("FAIL ftoi_shift: got %0d want 0", fx4_norm_shift[0]);
        end
        checks++;
        if (fx4_significand_product[0] !== 64'h0000_4000_0000_0000) begin
            errors++;
            $display("FAIL product: got %h want 0000400000000000", fx4_significand_product[0]);
        end
        checks++;
        if (fx4_add_significand[0] !== 32'h5 || fx4_add_exponent[0] !== 8'h01) begin
            errors++;
            $display("FAIL ftoi_no_flush: got exp %h sig %h want 01 00000005",
                     fx4_add_exponent[0], fx4_add_significand[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic              valids [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vector_lane_mask_t masks [4];
        subcycle_t         subs [4];
        for (int k = 0; k < 4; k++) begin
            randomize_inputs();
            masks[k] = fx3_mask_value;
            subs[k] = fx3_subcycle;
            fx3_instruction_valid = valids[k];
            fx3_thread_idx = local_thread_idx_t'(k % 3);
            tick();
            checks++;
            if (fx4_instruction_valid !== valids[k] || fx4_thread_idx !== local_thread_idx_t'(k % 3)
                    || fx4_mask_value !== masks[k] || fx4_subcycle !== subs[k]) begin
                errors++;
                $display("FAIL b2b slot%0d: got v%b t%0d m%h s%0d want v%b t%0d m%h s%0d", k,
                         fx4_instruction_valid, fx4_thread_idx, fx4_mask_value, fx4_subcycle,
                         valids[k], k % 3, masks[k], subs[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        randomize_inputs();
        fx3_instruction_valid = 1'b1;
        tick();
        checks++;
        if (fx4_instruction_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b want 1", fx4_instruction_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (fx4_instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want 0", fx4_instruction_valid);
        end
        tick();
        reset = 1'b0;
        fx3_thread_idx = local_thread_idx_t'(3);
        tick();
        checks++;
        if (fx4_instruction_valid !== 1'b1 || fx4_thread_idx !== local_thread_idx_t'(3)) begin
            errors++;
            $display("FAIL post_reset_first: got v%b t%0d want v1 t3", fx4_instruction_valid,
                     fx4_thread_idx);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int          shift [L];
            logic [31:0] sig [L];
            logic [7:0]  ex [L];
            randomize_inputs();
            for (int i = 0; i < L; i++) begin
                shift[i] = ref_shift(fx3_instruction.alu_op, fx3_add_significand[i]);
                if (ref_flush(fx3_instruction.alu_op, fx3_add_exponent[i], fx3_add_significand[i]))
                begin
                    sig[i] = '0;
                    ex[i] = '0;
                end else begin
                    sig[i] = fx3_add_significand[i];
                    ex[i] = fx3_add_exponent[i];
                end
            end
            tick();
            checks++;
            if (fx4_instruction_valid !== fx3_instruction_valid
                    || fx4_instruction !== fx3_instruction || fx4_mask_value !== fx3_mask_value
                    || fx4_thread_idx !== fx3_thread_idx || fx4_subcycle !== fx3_subcycle
                    || fx4_result_is_inf !== fx3_result_is_inf
                    || fx4_result_is_nan !== fx3_result_is_nan
                    || fx4_add_result_sign !== fx3_add_result_sign
                    || fx4_logical_subtract !== fx3_logical_subtract
                    || fx4_mul_sign !== fx3_mul_sign) begin
                errors++;
                $display("FAIL rand_ctrl iter%0d: got v%b i%h m%h t%0d want v%b i%h m%h t%0d", n,
                         fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx,
                         fx3_instruction_valid, fx3_instruction, fx3_mask_value, fx3_thread_idx);
            end
            for (int i = 0; i < L; i++) begin
                checks++;
                if (int'(fx4_norm_shift[i]) != shift[i] || fx4_add_significand[i] !== sig[i]
                        || fx4_add_exponent[i] !== ex[i]
                        || fx4_mul_exponent[i] !== fx3_mul_exponent[i]
                        || fx4_significand_product[i] !== fx3_significand_product[i]) begin
                    errors++;
                    $display("FAIL rand_lane iter%0d lane%0d: got sh%0d sig%h exp%h want sh%0d sig%h exp%h",
                             n, i, fx4_norm_shift[i], fx4_add_significand[i], fx4_add_exponent[i],
                             shift[i], sig[i], ex[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_norm_shift();
        test_ftoi();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
